// File: rtl/sift_pkg.sv
// Shared constants and types for the SIFT front-end scan logic.
package sift_pkg;

    localparam int unsigned IMG_COLS = 640;
    localparam int unsigned IMG_ROWS = 480;
    localparam int unsigned COL_W    = 10;
    localparam int unsigned ROW_W    = 9;

    // Gaussian kernel radii; a KxK window needs K-1 = 2*radius prior rows/cols.
    localparam int unsigned WIN3_RAD = 1;
    localparam int unsigned WIN5_RAD = 2;
    localparam int unsigned WIN7_RAD = 3;

    localparam int unsigned STALL_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } scan_state_t;

    function automatic int unsigned win_thresh(input int unsigned rad);
        return 2 * rad;
    endfunction

endpackage

// File: rtl/scan_pos_cnt.sv
// Raster column/row position counter with enable, clear, wrap and last-pixel flags.
module scan_pos_cnt
    import sift_pkg::*;
#(
    parameter int unsigned COLS = IMG_COLS,
    parameter int unsigned ROWS = IMG_ROWS,
    parameter int unsigned CW   = COL_W,
    parameter int unsigned RW   = ROW_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_last,
    output logic          last_pix
);

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    assign col_last = (col == COL_MAX);
    assign last_pix = col_last && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Raster-scan sequencer: line-buffer write port, window-valid strobes, end-of-frame.
// Optional stall counter enabled by defining SCAN_STALL_CNT_EN.
module scan_seq_ctrl
    import sift_pkg::*;
#(
    parameter int unsigned COLS = IMG_COLS,
    parameter int unsigned ROWS = IMG_ROWS,
    parameter int unsigned CW   = COL_W,
    parameter int unsigned RW   = ROW_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          busy,
    output logic          lb_wr_en,
    output logic [CW-1:0] lb_addr,
    output logic [RW-1:0] pix_row,
    output logic          lb_rot,
    output logic          win3_valid,
    output logic          win5_valid,
    output logic          win7_valid,
    output logic          frame_done,
    output logic          overrun_err
`ifdef SCAN_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam logic [CW-1:0] C3 = CW'(win_thresh(WIN3_RAD));
    localparam logic [CW-1:0] C5 = CW'(win_thresh(WIN5_RAD));
    localparam logic [CW-1:0] C7 = CW'(win_thresh(WIN7_RAD));
    localparam logic [RW-1:0] R3 = RW'(win_thresh(WIN3_RAD));
    localparam logic [RW-1:0] R5 = RW'(win_thresh(WIN5_RAD));
    localparam logic [RW-1:0] R7 = RW'(win_thresh(WIN7_RAD));

    scan_state_t   state;
    logic          accept;
    logic          arm;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          last_pix;

    assign accept = (state == RUN) && in_valid;
    assign arm    = (state == IDLE) && start;

    scan_pos_cnt #(
        .COLS(COLS),
        .ROWS(ROWS),
        .CW  (CW),
        .RW  (RW)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (arm),
        .en      (accept),
        .col     (col),
        .row     (row),
        .col_last(col_last),
        .last_pix(last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            lb_wr_en    <= 1'b0;
            lb_addr     <= '0;
            pix_row     <= '0;
            lb_rot      <= 1'b0;
            win3_valid  <= 1'b0;
            win5_valid  <= 1'b0;
            win7_valid  <= 1'b0;
            frame_done  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Per-pixel outputs reflect the position before the counter advances.
            lb_wr_en   <= accept;
            lb_addr    <= accept ? col : '0;
            pix_row    <= accept ? row : '0;
            lb_rot     <= accept && col_last;
            win3_valid <= accept && (row >= R3) && (col >= C3);
            win5_valid <= accept && (row >= R5) && (col >= C5);
            win7_valid <= accept && (row >= R7) && (col >= C7);
            frame_done <= accept && last_pix;

            // Set has priority over the clear from an accepted start.
            if (in_valid && (state != RUN)) begin
                overrun_err <= 1'b1;
            end else if (arm) begin
                overrun_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && last_pix) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (arm) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && !in_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: an 8x6 instance for frame tests, a 640x480 one for row timing.
module tb_scan_seq_ctrl;

    localparam int SC = 8;
    localparam int SR = 6;
    localparam int NPIX = SC * SR;

    typedef struct {
        int idx;
        int addr;
        int row;
        bit w3;
        bit w5;
        bit w7;
        bit rot;
        bit done;
    } vec_t;

    logic clk;
    logic rst_n;

    logic s_start, s_valid, s_busy, s_wr, s_rot, s_w3, s_w5, s_w7, s_done, s_ovr;
    logic [2:0] s_addr;
    logic [2:0] s_row;

    logic b_start, b_valid, b_busy, b_wr, b_rot, b_w3, b_w5, b_w7, b_done, b_ovr;
    logic [9:0] b_addr;
    logic [8:0] b_row;

`ifdef SCAN_STALL_CNT_EN
    logic [19:0] s_stall;
    logic [19:0] b_stall;
`endif

    int passed = 0;
    int total  = 0;

    scan_seq_ctrl #(
        .COLS(SC),
        .ROWS(SR),
        .CW  (3),
        .RW  (3)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .in_valid   (s_valid),
        .busy       (s_busy),
        .lb_wr_en   (s_wr),
        .lb_addr    (s_addr),
        .pix_row    (s_row),
        .lb_rot     (s_rot),
        .win3_valid (s_w3),
        .win5_valid (s_w5),
        .win7_valid (s_w7),
        .frame_done (s_done),
        .overrun_err(s_ovr)
`ifdef SCAN_STALL_CNT_EN
        ,
        .stall_cnt  (s_stall)
`endif
    );

    scan_seq_ctrl u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .in_valid   (b_valid),
        .busy       (b_busy),
        .lb_wr_en   (b_wr),
        .lb_addr    (b_addr),
        .pix_row    (b_row),
        .lb_rot     (b_rot),
        .win3_valid (b_w3),
        .win5_valid (b_w5),
        .win7_valid (b_w7),
        .frame_done (b_done),
        .overrun_err(b_ovr)
`ifdef SCAN_STALL_CNT_EN
        ,
        .stall_cnt  (b_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives one 8x6 frame (optionally with a stall cycle between pixels) and checks it.
    task automatic run_frame(input bit do_start, input bit gaps, input string tag);
        int   cap_addr[NPIX];
        int   cap_row[NPIX];
        bit   cap_wr[NPIX];
        bit   cap_w3[NPIX];
        bit   cap_w5[NPIX];
        bit   cap_w7[NPIX];
        bit   cap_rot[NPIX];
        bit   cap_done[NPIX];
        bit   cap_busy[NPIX];
        vec_t vecs[9];
        int   gap_bad = 0;
        int   pos_bad = 0;
        int   n3 = 0, n5 = 0, n7 = 0, nrot = 0, ndone = 0;
        int   e3 = 0, e5 = 0, e7 = 0;

        vecs[0] = '{0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{7,  7, 0, 0, 0, 0, 1, 0};
        vecs[2] = '{17, 1, 2, 0, 0, 0, 0, 0};
        vecs[3] = '{18, 2, 2, 1, 0, 0, 0, 0};
        vecs[4] = '{35, 3, 4, 1, 0, 0, 0, 0};
        vecs[5] = '{36, 4, 4, 1, 1, 0, 0, 0};
        vecs[6] = '{39, 7, 4, 1, 1, 0, 1, 0};
        vecs[7] = '{40, 0, 5, 0, 0, 0, 0, 0};
        vecs[8] = '{47, 7, 5, 1, 1, 0, 1, 1};

        if (do_start) begin
            s_start = 1'b1;
            s_valid = 1'b0;
            tick();
            s_start = 1'b0;
            chk({tag, "_busy_rise"}, s_busy, 1);
        end

        for (int i = 0; i < NPIX; i++) begin
            s_valid = 1'b1;
            tick();
            cap_addr[i] = s_addr;
            cap_row[i]  = s_row;
            cap_wr[i]   = s_wr;
            cap_w3[i]   = s_w3;
            cap_w5[i]   = s_w5;
            cap_w7[i]   = s_w7;
            cap_rot[i]  = s_rot;
            cap_done[i] = s_done;
            cap_busy[i] = s_busy;
            if (gaps && i < NPIX - 1) begin
                s_valid = 1'b0;
                tick();
                if (s_wr || s_rot || s_w3 || s_w5 || s_w7 || s_done) gap_bad++;
            end
        end
        s_valid = 1'b0;

`ifdef SCAN_STALL_CNT_EN
        chk({tag, "_stall_at_done"}, s_stall, gaps ? NPIX - 1 : 0);
`endif

        tick();
        chk({tag, "_done_clears"}, s_done, 0);
        chk({tag, "_wr_after"}, s_wr, 0);
        chk({tag, "_busy_after"}, s_busy, 0);

        for (int i = 0; i < NPIX; i++) begin
            if (!cap_wr[i] || cap_addr[i] != i % SC || cap_row[i] != i / SC) pos_bad++;
            n3    += int'(cap_w3[i]);
            n5    += int'(cap_w5[i]);
            n7    += int'(cap_w7[i]);
            nrot  += int'(cap_rot[i]);
            ndone += int'(cap_done[i]);
        end
        for (int r = 0; r < SR; r++) begin
            for (int c = 0; c < SC; c++) begin
                if (r >= 2 && c >= 2) e3++;
                if (r >= 4 && c >= 4) e5++;
                if (r >= 6 && c >= 6) e7++;
            end
        end

        chk({tag, "_pos_seq_errs"}, pos_bad, 0);
        chk({tag, "_gap_strobes"}, gap_bad, 0);
        chk({tag, "_rot_count"}, nrot, SR);
        chk({tag, "_w3_count"}, n3, e3);
        chk({tag, "_w5_count"}, n5, e5);
        chk({tag, "_w7_count"}, n7, e7);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_busy_pix46"}, cap_busy[NPIX-2], 1);
        chk({tag, "_busy_fall"}, cap_busy[NPIX-1], 0);

        for (int v = 0; v < 9; v++) begin
            int k;
            k = vecs[v].idx;
            chk($sformatf("%s_v%0d_addr", tag, k), cap_addr[k], vecs[v].addr);
            chk($sformatf("%s_v%0d_row", tag, k), cap_row[k], vecs[v].row);
            chk($sformatf("%s_v%0d_w3", tag, k), cap_w3[k], vecs[v].w3);
            chk($sformatf("%s_v%0d_w5", tag, k), cap_w5[k], vecs[v].w5);
            chk($sformatf("%s_v%0d_w7", tag, k), cap_w7[k], vecs[v].w7);
            chk($sformatf("%s_v%0d_rot", tag, k), cap_rot[k], vecs[v].rot);
            chk($sformatf("%s_v%0d_done", tag, k), cap_done[k], vecs[v].done);
        end
    endtask

    initial begin
        int idle_bad;
        int done_seen;
        int first_w7;
        int first_rot;
        int first_w3;
        int w7_addr;
        int w7_row;

        rst_n   = 1'b0;
        s_start = 1'b0;
        s_valid = 1'b0;
        b_start = 1'b0;
        b_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset and idle: everything quiet.
        idle_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_busy || s_wr || s_addr != 0 || s_row != 0 || s_rot || s_w3 || s_w5 ||
                s_w7 || s_done || s_ovr) idle_bad++;
        end
        chk("idle_small_nonzero", idle_bad, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_ovr", s_ovr, 0);
        chk("rst_big_busy", b_busy, 0);
        chk("rst_big_addr", b_addr, 0);
        chk("rst_big_row", b_row, 0);
`ifdef SCAN_STALL_CNT_EN
        chk("rst_stall", s_stall, 0);
`endif

        run_frame(1'b1, 1'b0, "f1");

        // Overrun: sticky, cleared by start, set wins over clear.
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("ovr_set", s_ovr, 1);
        tick();
        tick();
        chk("ovr_sticky", s_ovr, 1);
        chk("ovr_pix_not_started", s_busy, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("ovr_cleared_by_start", s_ovr, 0);
        chk("ovr_start_busy", s_busy, 1);
        run_frame(1'b0, 1'b1, "f2");

        s_valid = 1'b1;
        tick();
        chk("ovr_set2", s_ovr, 1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_valid = 1'b0;
        chk("ovr_set_wins", s_ovr, 1);
        chk("ovr_set_wins_busy", s_busy, 1);
        run_frame(1'b0, 1'b0, "f3");

        // Asynchronous reset mid-frame.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("pre_rst_addr", s_addr, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr", s_wr, 0);
        chk("async_rst_busy", s_busy, 0);
        chk("async_rst_addr", s_addr, 0);
        s_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_done || s_busy) done_seen++;
        end
        chk("post_rst_quiet", done_seen, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("restart_wr", s_wr, 1);
        chk("restart_addr", s_addr, 0);
        chk("restart_row", s_row, 0);

        // Full-size geometry: first row wrap and first 7x7 window.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        first_w7  = -1;
        first_rot = -1;
        first_w3  = -1;
        w7_addr   = -1;
        w7_row    = -1;
        done_seen = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (b_done) done_seen++;
            if (b_rot && first_rot < 0) first_rot = i;
            if (b_w3 && first_w3 < 0) first_w3 = i;
            if (b_w7) begin
                first_w7 = i;
                w7_addr  = b_addr;
                w7_row   = b_row;
                break;
            end
        end
        chk("big_first_rot", first_rot, 639);
        chk("big_first_w3", first_w3, 2 * 640 + 2);
        chk("big_first_w7", first_w7, 6 * 640 + 6);
        chk("big_w7_addr", w7_addr, 6);
        chk("big_w7_row", w7_row, 6);
        chk("big_busy_mid", b_busy, 1);
        chk("big_no_done", done_seen, 0);
        b_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
